// File: rtl/hv_dac_sequencer.sv
// rtl/hv_dac_sequencer.sv - snapshots 32 HV bias setpoints and shifts them into two 16-ch serial DACs
// Optional macro HV_SKIP_UNCHANGED_EN: skip channels whose setpoint matches the last value sent.
module hv_dac_sequencer #(
  parameter int CLK_DIV = 4
) (
  input  logic             dtc_clk,
  input  logic             rst,
  input  logic [31:0][11:0] hv_dac_data,
  input  logic             hv_update,
  output logic             busy,
  output logic             done,
  output logic             dac_sclk,
  output logic             dac_sdi,
  output logic [1:0]       dac_cs_n
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SCAN,
    S_SHIFT,
    S_GAP,
    S_FINISH
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [11:0] snap [32];
  logic [4:0]  ch;
  logic        pending;
  logic [7:0]  div_cnt;
  logic        phase_hi;
  logic [3:0]  bit_cnt;
  logic [15:0] shift_reg;
  logic        div_end;
  logic        last_ch;
  logic        skip_ch;

  assign div_end = (div_cnt == DIV_LAST);
  assign last_ch = (ch == 5'd31);

`ifdef HV_SKIP_UNCHANGED_EN
  logic [11:0] last_sent [32];
  logic [31:0] sent_vld;

  assign skip_ch = sent_vld[ch] && (snap[ch] == last_sent[ch]);

  // A channel only counts as sent once its full frame and GAP have gone out.
  always_ff @(posedge dtc_clk) begin
    if (rst) begin
      sent_vld <= '0;
    end else if (state == S_GAP && div_end) begin
      sent_vld[ch] <= 1'b1;
    end
  end

  always_ff @(posedge dtc_clk) begin
    if (state == S_GAP && div_end) begin
      last_sent[ch] <= snap[ch];
    end
  end
`else
  assign skip_ch = 1'b0;
`endif

  always_ff @(posedge dtc_clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (hv_update || pending) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        state_nxt = S_SCAN;
      end
      S_SCAN: begin
        if (skip_ch) begin
          state_nxt = last_ch ? S_FINISH : S_SCAN;
        end else begin
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (div_end && phase_hi && (bit_cnt == 4'd0)) begin
          state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (div_end) begin
          state_nxt = last_ch ? S_FINISH : S_SCAN;
        end
      end
      S_FINISH: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge dtc_clk) begin
    if (rst) begin
      ch        <= '0;
      pending   <= 1'b0;
      div_cnt   <= '0;
      phase_hi  <= 1'b0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      for (int i = 0; i < 32; i++) begin
        snap[i] <= '0;
      end
    end else begin
      // One-deep request latch: in IDLE any request is consumed by the move to LOAD.
      if (state == S_IDLE) begin
        pending <= 1'b0;
      end else if (hv_update) begin
        pending <= 1'b1;
      end

      case (state)
        S_LOAD: begin
          for (int i = 0; i < 32; i++) begin
            snap[i] <= hv_dac_data[i];
          end
          ch <= '0;
        end
        S_SCAN: begin
          shift_reg <= {ch[3:0], snap[ch]};
          div_cnt   <= '0;
          phase_hi  <= 1'b0;
          bit_cnt   <= 4'd15;
          if (skip_ch && !last_ch) begin
            ch <= ch + 5'd1;
          end
        end
        S_SHIFT: begin
          if (div_end) begin
            div_cnt <= '0;
            if (!phase_hi) begin
              phase_hi <= 1'b1;
            end else begin
              // Next bit is presented as the low phase begins; SCLK rises mid-bit.
              phase_hi  <= 1'b0;
              shift_reg <= {shift_reg[14:0], 1'b0};
              bit_cnt   <= bit_cnt - 4'd1;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        S_GAP: begin
          if (div_end) begin
            div_cnt <= '0;
            if (!last_ch) begin
              ch <= ch + 5'd1;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy     = (state != S_IDLE);
  assign done     = (state == S_FINISH);
  assign dac_sclk = (state == S_SHIFT) && phase_hi;
  assign dac_sdi  = (state == S_SHIFT) && shift_reg[15];
  assign dac_cs_n = (state != S_SHIFT) ? 2'b11 : (ch[4] ? 2'b01 : 2'b10);

endmodule

// File: tb/tb_hv_dac_sequencer.sv
// tb/tb_hv_dac_sequencer.sv - self-checking bench for hv_dac_sequencer (CLK_DIV=4 and CLK_DIV=1 instances)
module tb_hv_dac_sequencer;

  logic             dtc_clk = 1'b0;
  logic             rst = 1'b1;
  logic [31:0][11:0] hv_dac_data;
  logic             hv_update = 1'b0;
  logic             hv_update1 = 1'b0;
  logic             busy0, done0, dac_sclk0, dac_sdi0;
  logic             busy1, done1, dac_sclk1, dac_sdi1;
  logic [1:0]       dac_cs_n0, dac_cs_n1;

  always #5 dtc_clk = ~dtc_clk;

  hv_dac_sequencer #(.CLK_DIV(4)) u_dut (
    .dtc_clk(dtc_clk), .rst(rst), .hv_dac_data(hv_dac_data), .hv_update(hv_update),
    .busy(busy0), .done(done0), .dac_sclk(dac_sclk0), .dac_sdi(dac_sdi0), .dac_cs_n(dac_cs_n0)
  );

  hv_dac_sequencer #(.CLK_DIV(1)) u_dut1 (
    .dtc_clk(dtc_clk), .rst(rst), .hv_dac_data(hv_dac_data), .hv_update(hv_update1),
    .busy(busy1), .done(done1), .dac_sclk(dac_sclk1), .dac_sdi(dac_sdi1), .dac_cs_n(dac_cs_n1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic mon_en = 1'b0;

  logic [17:0] exp_q [$];
  logic [15:0] rx_log [$];
  int          exp_len [2];
`ifdef HV_SKIP_UNCHANGED_EN
  logic [11:0] m_last [2][32];
  logic        m_vld  [2][32];
`endif

  logic [1:0]  sclk_w, sdi_w, busy_w, done_w;
  logic [1:0]  cs_w [2];
  assign sclk_w = {dac_sclk1, dac_sclk0};
  assign sdi_w  = {dac_sdi1, dac_sdi0};
  assign busy_w = {busy1, busy0};
  assign done_w = {done1, done0};
  assign cs_w[0] = dac_cs_n0;
  assign cs_w[1] = dac_cs_n1;

  logic        prev_s [2];
  logic        prev_d [2];
  logic        prev_b [2];
  logic        prev_dn [2];
  logic [1:0]  prev_c [2];
  logic [15:0] cur [2];
  int          nbits [2];
  int          frames_rx [2];
  int          load_cyc [2];
  int          done_cyc [2];
  int          done_cnt [2];
  int          seq_len [2];
  int          gap [2];
  int          sclk_rises = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge dtc_clk) cyc <= cyc + 1;

  // Frame capture and protocol checks for both instances, sampled mid-cycle.
  always @(negedge dtc_clk) begin
    logic s, d, b, dn;
    logic [1:0] c;
    logic [17:0] e;
    for (int k = 0; k < 2; k++) begin
      s = sclk_w[k]; d = sdi_w[k]; b = busy_w[k]; dn = done_w[k]; c = cs_w[k];
      if (mon_en) begin
        if (c != prev_c[k]) check("cs_exclusive", {31'd0, c != 2'b00}, 1);
        if (s && !prev_s[k]) begin
          if (k == 0) sclk_rises++;
          if (c == 2'b11) begin
            check("sclk_without_cs", 1, 0);
          end else begin
            check("sdi_stable_at_rise", d, prev_d[k]);
            cur[k] = {cur[k][14:0], d};
            nbits[k]++;
          end
        end
        if (c == 2'b11 && prev_c[k] != 2'b11) begin
          if (nbits[k] == 16) begin
            if (exp_q.size() == 0) begin
              check("frame_unexpected", 1, 0);
            end else begin
              e = exp_q.pop_front();
              check("frame_data", cur[k], e[15:0]);
              check("frame_cs", prev_c[k], e[17:16]);
            end
            rx_log.push_back(cur[k]);
            frames_rx[k]++;
          end
          nbits[k] = 0;
        end
        if (b && !prev_b[k]) begin
          load_cyc[k] = cyc;
          gap[k] = cyc - done_cyc[k];
        end
        if (prev_dn[k]) check("busy_after_done", b, 0);
        if (dn) begin
          seq_len[k] = cyc - load_cyc[k] + 1;
          done_cyc[k] = cyc;
          done_cnt[k]++;
        end
      end
      prev_s[k] = s; prev_d[k] = d; prev_b[k] = b; prev_dn[k] = dn; prev_c[k] = c;
    end
  end

  task automatic tick();
    @(negedge dtc_clk);
    #1;
  endtask

  task automatic model_clear();
`ifdef HV_SKIP_UNCHANGED_EN
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 32; i++) m_vld[k][i] = 1'b0;
`endif
  endtask

  task automatic push_seq(input int k);
    int len;
    int per_ch;
    logic [4:0] c5;
    logic [11:0] v;
    logic send;
    len = 2;
    per_ch = 1 + 33 * ((k == 0) ? 4 : 1);
    for (int i = 0; i < 32; i++) begin
      c5 = 5'(i);
      v = hv_dac_data[i];
      send = 1'b1;
`ifdef HV_SKIP_UNCHANGED_EN
      if (m_vld[k][i] && m_last[k][i] == v) send = 1'b0;
      m_last[k][i] = v;
      m_vld[k][i] = 1'b1;
`endif
      if (send) begin
        exp_q.push_back({(i < 16) ? 2'b10 : 2'b01, c5[3:0], v});
        len += per_ch;
      end else begin
        len += 1;
      end
    end
    exp_len[k] = len;
  endtask

  task automatic strobe0();
    hv_update = 1'b1;
    tick();
    hv_update = 1'b0;
  endtask

  task automatic wait_done(input int k, input int budget);
    int target;
    target = done_cnt[k] + 1;
    for (int i = 0; i < budget && done_cnt[k] < target; i++) tick();
    check($sformatf("done%0d_within_budget", k), {31'd0, done_cnt[k] >= target}, 1);
  endtask

  task automatic randomize_data();
    for (int i = 0; i < 32; i++) hv_dac_data[i] = 12'($urandom_range(0, 4095));
  endtask

  typedef struct {
    logic       rst;
    logic       upd;
    logic [1:0] cs;
    logic       sclk;
    logic       sdi;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int base;
    int r;
    int idx20;
    int reached;

    for (int i = 0; i < 32; i++) hv_dac_data[i] = 12'h100 + 12'(i);

    // Reset, then strobe-to-first-SCLK timing with frame 0 = 16'h0100.
    tbl[0] = '{1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0};

    for (int i = 0; i < 9; i++) begin
      rst = tbl[i].rst;
      hv_update = tbl[i].upd;
      if (tbl[i].rst) model_clear();
      if (tbl[i].upd) push_seq(0);
      tick();
      check($sformatf("row%0d_cs_n", i), dac_cs_n0, tbl[i].cs);
      check($sformatf("row%0d_sclk", i), dac_sclk0, tbl[i].sclk);
      check($sformatf("row%0d_sdi", i), dac_sdi0, tbl[i].sdi);
      check($sformatf("row%0d_busy", i), busy0, tbl[i].busy);
      check($sformatf("row%0d_done", i), done0, tbl[i].done);
      if (i == 0) mon_en = 1'b1;
    end
    hv_update = 1'b0;

    // Snapshot: change channel 20 while frame 3 is in flight.
    for (int i = 0; i < 2000 && frames_rx[0] < 3; i++) tick();
    check("reach_frame3", {31'd0, frames_rx[0] >= 3}, 1);
    hv_dac_data[20] = 12'hABC;
    wait_done(0, 5000);
    check("seq1_len", seq_len[0], 4258);
    check("seq1_len_model", seq_len[0], exp_len[0]);
    check("seq1_frame20_old", rx_log[20], 16'h4114);

    // Second sequence carries the new value; three strobes mid-sequence give one extra run.
    push_seq(0);
    strobe0();
    repeat (20) tick();
    check("busy_during_seq2", busy0, 1);
    for (int p = 0; p < 3; p++) begin
      if (p == 0) push_seq(0);
      strobe0();
      repeat (10) tick();
    end
    wait_done(0, 5000);
`ifdef HV_SKIP_UNCHANGED_EN
    idx20 = 32;
`else
    idx20 = 52;
`endif
    check("seq2_len", seq_len[0], exp_len[0]);
    check("seq2_frame20_new", rx_log[idx20], 16'h4ABC);
    wait_done(0, 5000);
    check("pending_gap", gap[0], 2);
    check("seq3_len", seq_len[0], exp_len[0]);
    repeat (300) tick();
    check("no_third_seq", done_cnt[0], 3);
    check("idle_after_pending", busy0, 0);
    check("queue_empty_after_pending", exp_q.size(), 0);

    // Reset during bit 7 of channel 5.
    randomize_data();
    push_seq(0);
    base = frames_rx[0];
    strobe0();
    reached = 0;
    for (int i = 0; i < 4000 && !reached; i++) begin
      if (frames_rx[0] == base + 5 && nbits[0] == 8) reached = 1;
      else tick();
    end
    check("reach_ch5_bit7", reached, 1);
    rst = 1'b1;
    model_clear();
    tick();
    check("rst_cs_n", dac_cs_n0, 2'b11);
    check("rst_sclk", dac_sclk0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    rst = 1'b0;
    exp_q.delete();
    r = sclk_rises;
    repeat (200) tick();
    check("no_sclk_after_rst", sclk_rises, r);
    check("idle_after_rst", busy0, 0);

    // Fresh full sequence with random data.
    randomize_data();
    push_seq(0);
    strobe0();
    wait_done(0, 5000);
    check("seq_rand_len", seq_len[0], exp_len[0]);
    check("queue_empty_rand", exp_q.size(), 0);

    // Only channels 3 and 30 change.
    hv_dac_data[3]  = hv_dac_data[3] ^ 12'h001;
    hv_dac_data[30] = hv_dac_data[30] ^ 12'h800;
    base = frames_rx[0];
    push_seq(0);
    strobe0();
    wait_done(0, 5000);
    check("seq_two_changed_len", seq_len[0], exp_len[0]);
`ifdef HV_SKIP_UNCHANGED_EN
    check("skip_len", seq_len[0], 30 + 2 * 133 + 2);
    check("skip_frames", frames_rx[0] - base, 2);
`else
    check("full_frames", frames_rx[0] - base, 32);
`endif
    check("queue_empty_two_changed", exp_q.size(), 0);

    // CLK_DIV=1 stress on the second instance.
    randomize_data();
    push_seq(1);
    base = frames_rx[1];
    hv_update1 = 1'b1;
    tick();
    hv_update1 = 1'b0;
    wait_done(1, 2000);
    check("div1_len", seq_len[1], exp_len[1]);
    check("div1_frames", frames_rx[1] - base, 32);
    check("queue_empty_div1", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hv_dac_sequencer.md
# hv_dac_sequencer

Serial loader for the APD bias high-voltage DACs on the FEC. On a `hv_update` strobe from the DTC command decoder it snapshots the 32 twelve-bit `hv_dac_data` words. It then shifts them, one 16-bit frame per channel, into two 16-channel serial DACs over a shared SCLK/SDI pair with per-chip chip-selects. The block reports progress with `busy` and `done`. It sits between the DTC register file and the FEC HV DAC pins.

## Interface
- `CLK_DIV`, default 4: SCLK half-period in `dtc_clk` cycles; legal range 1..255.
- `dtc_clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `hv_dac_data`  in  [31:0][11:0]  bias setpoints; index = channel.
- `hv_update`  in  1  one-cycle start strobe.
- `busy`  out  1  high while a sequence is snapshotting or shifting.
- `done`  out  1  one-cycle pulse when a sequence completes.
- `dac_sclk`  out  1  serial clock; idles low.
- `dac_sdi`  out  1  serial data, MSB first.
- `dac_cs_n`  out  2  active-low chip selects: bit 0 = channels 0-15, bit 1 = channels 16-31.

## Operation
- States: IDLE, LOAD, SCAN, SHIFT, GAP, FINISH.
- **IDLE:**
  - `hv_update`=1 or `pending`=1 moves to LOAD.
  - `pending` is cleared on that transition.
- **LOAD (1 cycle):**
  - Copies all 32 `hv_dac_data` words into the internal `snap` array.
  - Sets channel counter `ch`=0.
  - Goes to SCAN.
  - Register writes during a sequence therefore do not affect it.
- **SCAN (1 cycle):**
  - Builds frame = {`ch[3:0]`, `snap[ch]`}, 16 bits.
  - Goes to SHIFT, or to the skip path (see Configuration).
- **SHIFT:**
  - `dac_cs_n[ch[4]]`=0; the other chip-select stays 1.
  - 16 bits, MSB first. Each bit has a low phase then a high phase, each `CLK_DIV` cycles.
  - `dac_sdi` changes only on entry to a low phase. The DAC samples on the SCLK rising edge.
  - After the high phase of bit 0, goes to GAP.
- **GAP:**
  - `dac_cs_n`=2'b11, SCLK low, for `CLK_DIV` cycles.
  - If `ch`=31, goes to FINISH; otherwise `ch`+1 and goes to SCAN.
- **FINISH (1 cycle):**
  - Pulses `done`, then returns to IDLE.
  - If `pending`=1, the next LOAD follows immediately after this IDLE cycle.
- **`hv_update` while not IDLE:** sets the one-deep flag `pending`; further strobes are absorbed. `hv_update` in IDLE starts directly.
- **`busy`:** 1 in LOAD, SCAN, SHIFT, GAP and FINISH; 0 in IDLE.
- **Reset**, in any state, takes effect at the next edge:
  - State returns to IDLE; `ch`=0, `pending`=0, `snap` = all zero.
  - Outputs: `dac_cs_n`=2'b11, `dac_sclk`=0, `dac_sdi`=0, `busy`=0, `done`=0.
  - A partial frame is abandoned; the chip-select deasserts with no further SCLK edges.

## Timing
- Strobe to start: `hv_update` at edge N → LOAD at N+1 (`busy`=1) → SCAN at N+2 → `dac_cs_n` low at N+3.
- Per transmitted channel: 1 (SCAN) + 32·`CLK_DIV` (SHIFT) + `CLK_DIV` (GAP) cycles.
- Full sequence with `CLK_DIV`=4: 1 + 32·(1+132) + 1 = 4258 cycles from LOAD to FINISH inclusive.
- `done` is high for exactly one cycle, coincident with the last cycle of `busy`=1.
- Chip-select setup: `dac_cs_n` falls in the same cycle `dac_sdi` presents bit 15, which is `CLK_DIV` cycles before the first SCLK rise.
- Chip-select hold: `CLK_DIV` cycles after the last SCLK fall; at least `CLK_DIV` cycles with both chip-selects high between frames.
- At most one chip-select is low at any time.

## Configuration
- Macro: `HV_SKIP_UNCHANGED_EN`.
- **Defined:**
  - A `last_sent[31:0][11:0]` array and a `sent_vld[31:0]` flag vector are kept.
  - In SCAN, if `sent_vld[ch]`=1 and `snap[ch]`==`last_sent[ch]`, the channel is skipped: no SHIFT and no GAP. `ch` advances, or the FSM goes to FINISH on `ch`=31. The skip costs 1 cycle.
  - After a channel's GAP, `last_sent[ch]`=`snap[ch]` and `sent_vld[ch]`=1.
  - Reset clears `sent_vld`, so the first sequence after reset sends all 32 channels.
- **Undefined:** every sequence transmits all 32 frames; `last_sent` and `sent_vld` do not exist.

## Test plan
- **Basic load:** `CLK_DIV`=4, `hv_dac_data[i]`=12'h100+i, one `hv_update`.
  - Captured frames, in order: 16'h0100, 16'h1101, …, 16'hF10F on `cs_n[0]`, then 16'h0110 … 16'hF11F on `cs_n[1]`.
  - `done` at cycle 4258 after LOAD.
- **Snapshot:** change `hv_dac_data[20]` to 12'hABC during frame 3.
  - Frame 20 still carries the old value, 12'h114.
  - A later `hv_update` sends 16'h4ABC.
- **Pending:** three `hv_update` strobes during a sequence.
  - Exactly one extra sequence runs, starting 1 IDLE cycle after `done`; no third sequence.
- **Reset mid-frame:** assert `rst` during bit 7 of channel 5.
  - Next edge: `dac_cs_n`=2'b11, `dac_sclk`=0, `busy`=0.
  - No SCLK edges until a new `hv_update`.
- **`HV_SKIP_UNCHANGED_EN`:** after a full load, change only channels 3 and 30, then strobe.
  - Exactly 2 frames sent (16'h3xxx on `cs_n[0]`, 16'hExxx on `cs_n[1]`).
  - Sequence length = 30 + 2·133 + 2 cycles.
- **`CLK_DIV`=1 stress:** SCLK toggles every cycle.
  - `dac_sdi` stable across every rising SCLK.
  - The two chip-selects are never low together.
